// File: rtl/kbd_queue.sv
// kbd_queue: PS/2 set-2 scancode decoder with modifier tracking and a show-ahead key-event FIFO.
// Define KBD_ASCII_EN to push translated ASCII/arrow codes instead of raw {release, ext, code} events.
module kbd_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ps2_hit,
  input  logic [7:0]            ps2_data,
  input  logic                  rd,
  input  logic                  clr,
  output logic [9:0]            dout,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [2:0]            mods,
  output logic [1:0]            hit_cnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP} state_t;
  state_t                r_state, w_next;
  logic [2:0]            r_skip, w_skip;
  logic                  r_lsh, r_rsh, r_ctrl, r_alt;
  logic                  w_ev, w_rel, w_ext, w_junk;
  logic                  w_push, w_pop, w_acc, w_full;
  logic [9:0]            w_entry;
  logic [9:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wp, r_rp;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ovf;
  logic [1:0]            r_hit;
  assign w_junk = ps2_data == 8'h00 || ps2_data == 8'hAA || ps2_data == 8'hEE ||
                  ps2_data == 8'hFA || ps2_data == 8'hFE || ps2_data == 8'hFF;
  always_comb begin
    w_next = r_state;
    w_skip = r_skip;
    w_ev   = 1'b0;
    w_rel  = 1'b0;
    w_ext  = 1'b0;
    if (ps2_hit) begin
      case (r_state)
        IDLE: begin
          if (ps2_data == 8'hE0) w_next = EXT;
          else if (ps2_data == 8'hF0) w_next = BRK;
          else if (ps2_data == 8'hE1) begin
            w_next = SKIP;
            w_skip = 3'd7;
          end else w_ev = !w_junk;
        end
        EXT: begin
          w_next = ps2_data == 8'hF0 ? EXTBRK : IDLE;
          w_ev   = ps2_data != 8'hF0 && ps2_data != 8'h12 && ps2_data != 8'h59;
          w_ext  = 1'b1;
        end
        BRK: begin
          w_next = IDLE;
          w_ev   = 1'b1;
          w_rel  = 1'b1;
        end
        EXTBRK: begin
          w_next = IDLE;
          w_ev   = 1'b1;
          w_rel  = 1'b1;
          w_ext  = 1'b1;
        end
        SKIP: begin
          w_skip = r_skip - 3'd1;
          w_next = r_skip <= 3'd1 ? IDLE : SKIP;
        end
        default: w_next = IDLE;
      endcase
    end
  end
`ifdef KBD_ASCII_EN
  logic       w_lv, w_dv, w_sv, w_av, w_mod;
  logic [4:0] w_li;
  logic [3:0] w_di;
  logic [7:0] w_sc, w_asc;
  assign w_mod = (!w_ext && (ps2_data == 8'h12 || ps2_data == 8'h59)) ||
                 ps2_data == 8'h14 || ps2_data == 8'h11;
  always_comb begin
    w_lv = 1'b1;
    w_li = 5'd0;
    w_dv = 1'b1;
    w_di = 4'd0;
    w_sv = 1'b1;
    w_sc = 8'h00;
    case (ps2_data)
      8'h1C: w_li = 5'd0;   8'h32: w_li = 5'd1;   8'h21: w_li = 5'd2;   8'h23: w_li = 5'd3;
      8'h24: w_li = 5'd4;   8'h2B: w_li = 5'd5;   8'h34: w_li = 5'd6;   8'h33: w_li = 5'd7;
      8'h43: w_li = 5'd8;   8'h3B: w_li = 5'd9;   8'h42: w_li = 5'd10;  8'h4B: w_li = 5'd11;
      8'h3A: w_li = 5'd12;  8'h31: w_li = 5'd13;  8'h44: w_li = 5'd14;  8'h4D: w_li = 5'd15;
      8'h15: w_li = 5'd16;  8'h2D: w_li = 5'd17;  8'h1B: w_li = 5'd18;  8'h2C: w_li = 5'd19;
      8'h3C: w_li = 5'd20;  8'h2A: w_li = 5'd21;  8'h1D: w_li = 5'd22;  8'h22: w_li = 5'd23;
      8'h35: w_li = 5'd24;  8'h1A: w_li = 5'd25;
      default: w_lv = 1'b0;
    endcase
    case (ps2_data)
      8'h45: w_di = 4'd0;  8'h16: w_di = 4'd1;  8'h1E: w_di = 4'd2;  8'h26: w_di = 4'd3;
      8'h25: w_di = 4'd4;  8'h2E: w_di = 4'd5;  8'h36: w_di = 4'd6;  8'h3D: w_di = 4'd7;
      8'h3E: w_di = 4'd8;  8'h46: w_di = 4'd9;
      default: w_dv = 1'b0;
    endcase
    case (ps2_data)
      8'h29: w_sc = 8'h20;  8'h5A: w_sc = 8'h0D;  8'h66: w_sc = 8'h08;
      8'h0D: w_sc = 8'h09;  8'h76: w_sc = 8'h1B;
      default: w_sv = 1'b0;
    endcase
    w_av  = 1'b0;
    w_asc = 8'h00;
    if (w_ext) begin
      w_av  = ps2_data == 8'h75 || ps2_data == 8'h72 || ps2_data == 8'h6B || ps2_data == 8'h74;
      w_asc = ps2_data == 8'h75 ? 8'h80 : ps2_data == 8'h72 ? 8'h81 : ps2_data == 8'h6B ? 8'h82 : 8'h83;
    end else if (w_lv) begin
      w_av  = 1'b1;
      w_asc = r_ctrl ? 8'(w_li) + 8'h01 : (r_lsh | r_rsh) ? 8'(w_li) + 8'h41 : 8'(w_li) + 8'h61;
    end else if (w_dv) begin
      w_av  = 1'b1;
      w_asc = 8'(w_di) + 8'h30;
    end else begin
      w_av  = w_sv;
      w_asc = w_sc;
    end
  end
  assign w_push  = w_ev && !w_rel && !w_mod && w_av;
  assign w_entry = {2'b00, w_asc};
`else
  assign w_push  = w_ev;
  assign w_entry = {w_rel, w_ext, ps2_data};
`endif
  // A full FIFO still accepts a push when the same cycle pops the head
  assign w_full = r_count == (DEPTH_LOG2+1)'(DEPTH);
  assign w_pop  = rd && r_count != '0 && !clr;
  assign w_acc  = w_push && (!w_full || w_pop) && !clr;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_skip  <= 3'd0;
      r_lsh   <= 1'b0;
      r_rsh   <= 1'b0;
      r_ctrl  <= 1'b0;
      r_alt   <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_hit   <= 2'd0;
    end else begin
      r_state <= w_next;
      r_skip  <= w_skip;
      if (w_ev && !w_ext && ps2_data == 8'h12) r_lsh <= !w_rel;
      if (w_ev && !w_ext && ps2_data == 8'h59) r_rsh <= !w_rel;
      if (w_ev && ps2_data == 8'h14) r_ctrl <= !w_rel;
      if (w_ev && ps2_data == 8'h11) r_alt <= !w_rel;
      if (w_acc) r_hit <= r_hit + 2'd1;
      if (clr) begin
        r_wp    <= '0;
        r_rp    <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_acc) r_wp <= r_wp + 1'b1;
        if (w_pop) r_rp <= r_rp + 1'b1;
        r_count <= r_count + (DEPTH_LOG2+1)'(w_acc) - (DEPTH_LOG2+1)'(w_pop);
        if (w_push && !w_acc) r_ovf <= 1'b1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (w_acc) r_mem[r_wp] <= w_entry;
  end
  assign empty    = r_count == '0;
  assign dout     = empty ? 10'd0 : r_mem[r_rp];
  assign count    = r_count;
  assign overflow = r_ovf;
  assign mods     = {r_alt, r_ctrl, r_lsh | r_rsh};
  assign hit_cnt  = r_hit;
endmodule

// File: tb/tb_kbd_queue.sv
// tb_kbd_queue: directed scancode vectors; expected entries go to a scoreboard queue checked by a pop monitor.
module tb_kbd_queue;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_hit = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       rd = 1'b0;
  logic       clr = 1'b0;
  logic [9:0] dout;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [2:0] mods;
  logic [1:0] hit_cnt;
  int         total = 0;
  int         bad = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;

  kbd_queue #(.DEPTH_LOG2(4)) dut (
    .clock(clock), .reset_n(reset_n), .ps2_hit(ps2_hit), .ps2_data(ps2_data),
    .rd(rd), .clr(clr), .dout(dout), .empty(empty), .count(count),
    .overflow(overflow), .mods(mods), .hit_cnt(hit_cnt)
  );

  always #5 clock = ~clock;

  // Monitor: every head consumed by a pop must match the oldest expected entry
  always @(negedge clock) begin
    if (reset_n && rd && !empty && !clr) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected got=%h want=<none>", dout);
      end else begin
        mon_e = exp_q.pop_front();
        if (dout !== mon_e) begin
          bad++;
          $display("FAIL pop_entry got=%h want=%h", dout, mon_e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ps2_hit = 1'b1;
    ps2_data = b;
    tick();
    ps2_hit = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic drain();
    for (int g = 0; g < 40 && !empty; g++) pop();
    check("drain_empty", 16'(empty), 16'd1);
  endtask

  task automatic check_reset(input string n);
    check({n, "_dout"}, 16'(dout), 16'h000);
    check({n, "_empty"}, 16'(empty), 16'd1);
    check({n, "_count"}, 16'(count), 16'd0);
    check({n, "_ovf"}, 16'(overflow), 16'd0);
    check({n, "_mods"}, 16'(mods), 16'd0);
    check({n, "_hit"}, 16'(hit_cnt), 16'd0);
  endtask

  initial begin
    #2;
    check_reset("rst");
    tick();
    tick();
    reset_n = 1'b1;
    tick();
`ifdef KBD_ASCII_EN
    send(8'h12); send(8'h1C); exp_q.push_back(10'h041);
    send(8'hF0); send(8'h12);
    send(8'h1C); exp_q.push_back(10'h061);
    send(8'h14); send(8'h1C); exp_q.push_back(10'h001);
    check("asc_count", 16'(count), 16'd3);
    check("asc_mods", 16'(mods), 16'b010);
    check("asc_hit", 16'(hit_cnt), 16'd3);
    check("asc_head", 16'(dout), 16'h041);
    drain();
    send(8'hF0); send(8'h14);
    send(8'h16); exp_q.push_back(10'h031);
    send(8'hE0); send(8'h6B); exp_q.push_back(10'h082);
    send(8'h29); exp_q.push_back(10'h020);
    send(8'h07);
    check("asc_count2", 16'(count), 16'd3);
    check("asc_hit2", 16'(hit_cnt), 16'd2);
    drain();
`else
    send(8'h1C); exp_q.push_back(10'h01C);
    send(8'hF0); send(8'h1C); exp_q.push_back(10'h21C);
    check("raw_count", 16'(count), 16'd2);
    check("raw_hit", 16'(hit_cnt), 16'd2);
    check("raw_mods", 16'(mods), 16'd0);
    check("raw_head", 16'(dout), 16'h01C);
    drain();
    send(8'h12); exp_q.push_back(10'h012);
    check("shift_mods", 16'(mods), 16'b001);
    send(8'hF0); send(8'h12); exp_q.push_back(10'h212);
    check("shift_rel_mods", 16'(mods), 16'b000);
    drain();
    send(8'hE0); send(8'h75); exp_q.push_back(10'h175);
    send(8'hE0); send(8'hF0); send(8'h75); exp_q.push_back(10'h375);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check("pause_count", 16'(count), 16'd2);
    check("pause_mods", 16'(mods), 16'd0);
    send(8'h29); exp_q.push_back(10'h029);
    check("post_pause_count", 16'(count), 16'd3);
    check("post_pause_hit", 16'(hit_cnt), 16'd3);
    drain();
    for (int i = 0; i < 17; i++) begin
      send(8'h1C);
      if (i < 16) exp_q.push_back(10'h01C);
    end
    check("full_count", 16'(count), 16'd16);
    check("full_ovf", 16'(overflow), 16'd1);
    check("full_hit", 16'(hit_cnt), 16'd3);
    rd = 1'b1;
    send(8'h1C); exp_q.push_back(10'h01C);
    rd = 1'b0;
    check("full_rdpush_count", 16'(count), 16'd16);
    check("full_rdpush_ovf", 16'(overflow), 16'd1);
    check("full_rdpush_hit", 16'(hit_cnt), 16'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
    check("clr_count", 16'(count), 16'd0);
    check("clr_empty", 16'(empty), 16'd1);
    check("clr_ovf", 16'(overflow), 16'd0);
    check("clr_hit", 16'(hit_cnt), 16'd0);
    send(8'h16); exp_q.push_back(10'h016);
    rd = 1'b1;
    send(8'h1E); exp_q.push_back(10'h01E);
    rd = 1'b0;
    check("one_rdpush_count", 16'(count), 16'd1);
    check("one_rdpush_head", 16'(dout), 16'h01E);
    drain();
    pop();
    check("rd_empty_count", 16'(count), 16'd0);
    check("rd_empty_empty", 16'(empty), 16'd1);
    rd = 1'b1;
    send(8'h25); exp_q.push_back(10'h025);
    rd = 1'b0;
    check("empty_rdpush_count", 16'(count), 16'd1);
    check("empty_rdpush_hit", 16'(hit_cnt), 16'd3);
    drain();
    clr = 1'b1;
    send(8'h1C);
    clr = 1'b0;
    check("clr_push_count", 16'(count), 16'd0);
    check("clr_push_ovf", 16'(overflow), 16'd0);
    check("clr_push_hit", 16'(hit_cnt), 16'd3);
    send(8'h14); exp_q.push_back(10'h014);
    check("ctrl_mods", 16'(mods), 16'b010);
    send(8'hE0);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check_reset("midrst");
    tick();
    reset_n = 1'b1;
    tick();
    send(8'h75); exp_q.push_back(10'h075);
    check("midrst_count", 16'(count), 16'd1);
    check("midrst_head", 16'(dout), 16'h075);
    drain();
`endif
    check("sb_left", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
